// File: rtl/loop_nest_sequencer_pkg.sv
// loop_nest_pkg: shared types and constants for the loop nest sequencer.
//   state_t : sequencer states (IDLE, CHK, INNER, DONE)
//   Y_W     : width of the inner-step result bus
//   Y_MAX   : saturation value of the result bus
//   GATE_W  : width at which the outer gate sum is evaluated
package loop_nest_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHK   = 2'd1,
    ST_INNER = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int             Y_W    = 10;
  localparam logic [Y_W-1:0] Y_MAX  = 10'd1023;
  localparam int             GATE_W = 8;

endpackage

// File: rtl/loop_nest_sequencer_wrap_counter.sv
// wrap_counter: index counter that counts 0..LIMIT-1 and wraps to 0.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (count -> 0)
//   clr      : synchronous clear (count -> 0), wins over en
//   en       : advance by one, wrapping after LIMIT-1
//   count    : current value (registered)
//   at_limit : count == LIMIT-1
module wrap_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_limit
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  assign count    = count_reg;
  assign at_limit = (count_reg == LAST);

endmodule

// File: rtl/loop_nest_sequencer.sv
// loop_nest_sequencer: clocked two-level loop nest controller with a
// data-dependent gate evaluated once per outer iteration.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, aborts any run
//   start      : run request, honoured only in IDLE
//   wire1      : signed gate operand, latched when a start is accepted
//   busy       : run in progress (CHK / INNER)
//   done       : one-cycle pulse at end of run
//   step_valid : high for each inner-loop step
//   outer_idx  : current outer index
//   inner_idx  : current inner index
//   y          : inner steps executed in current/last run, saturating
//   skip_cnt   : (only with LOOP_NEST_STATS_EN) outer iterations whose
//                gate evaluated to 0 in the current run
// Optional feature macro: LOOP_NEST_STATS_EN
module loop_nest_sequencer
  import loop_nest_pkg::*;
#(
  parameter int OUTER_W = 4,
  parameter int INNER_W = 3,
  parameter int OUTER_N = 4,
  parameter int INNER_N = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [5:0]  wire1,
  output logic               busy,
  output logic               done,
  output logic               step_valid,
  output logic [OUTER_W-1:0] outer_idx,
  output logic [INNER_W-1:0] inner_idx,
  output logic [Y_W-1:0]     y
`ifdef LOOP_NEST_STATS_EN
  ,
  output logic [OUTER_W:0]   skip_cnt
`endif
);

  state_t              state_reg, state_next;
  logic signed [5:0]   op_reg;
  logic [Y_W-1:0]      y_reg;
  logic                busy_reg, done_reg, step_reg;
  logic [GATE_W-1:0]   gate_sum;
  logic                gate;
  logic                accept, outer_en, inner_en;
  logic                outer_last, inner_last;

  wrap_counter #(.W(OUTER_W), .LIMIT(OUTER_N)) u_outer (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (outer_en),
    .count    (outer_idx),
    .at_limit (outer_last)
  );

  wrap_counter #(.W(INNER_W), .LIMIT(INNER_N)) u_inner (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (inner_en),
    .count    (inner_idx),
    .at_limit (inner_last)
  );

  // Gate: index zero-extended plus operand sign-extended, wrapping at
  // GATE_W bits; odd parity selects the all-ones test on the index.
  always_comb begin
    gate_sum = GATE_W'(outer_idx) + GATE_W'(op_reg);
    gate     = (^gate_sum) ? (&outer_idx) : (op_reg != 6'sd0);
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    outer_en   = 1'b0;
    inner_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_CHK;
        end
      end
      ST_CHK: begin
        if (gate) begin
          state_next = ST_INNER;
        end else if (outer_last) begin
          state_next = ST_DONE;
        end else begin
          outer_en = 1'b1;
        end
      end
      ST_INNER: begin
        if (!inner_last) begin
          inner_en = 1'b1;
        end else if (!outer_last) begin
          // Inner counter wraps to 0 as the outer index advances.
          inner_en   = 1'b1;
          outer_en   = 1'b1;
          state_next = ST_CHK;
        end else begin
          // Final step: indices hold their last values for inspection.
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe without any input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      op_reg    <= '0;
      y_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      step_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == ST_CHK) || (state_next == ST_INNER);
      done_reg  <= (state_next == ST_DONE);
      step_reg  <= (state_next == ST_INNER);
      if (accept) begin
        op_reg <= wire1;
        y_reg  <= '0;
      end else if ((state_reg == ST_INNER) && (y_reg != Y_MAX)) begin
        y_reg <= y_reg + 1'b1;
      end
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign step_valid = step_reg;
  assign y          = y_reg;

`ifdef LOOP_NEST_STATS_EN
  logic [OUTER_W:0] skip_reg;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      skip_reg <= '0;
    end else if ((state_reg == ST_CHK) && !gate) begin
      skip_reg <= skip_reg + 1'b1;
    end
  end

  assign skip_cnt = skip_reg;
`endif

endmodule
